eth_filter_gate: RTL and testbench

//  Store-and-forward gate downstream of the RX parser/KV-lookup stage. Buffers each RX frame,

---
 rtl/eth_filter_gate.sv | 215 +++++++++++++++++++++
 tb/tb_eth_filter_gate.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/eth_filter_gate.sv
// eth_filter_gate: store-and-forward RX gate that pairs buffered frames with in-order KV verdicts,
// forwarding or discarding each frame; frames without a lookup pass, late verdicts fail open.
module eth_filter_gate #(
  parameter int         DATA_AW     = 9,
  parameter int         DESC_AW     = 4,
  parameter int         TIMEOUT     = 1024,
  parameter logic [1:0] DROP_STATUS = 2'b11
) (
  input  logic        clk156,
  input  logic        eth_rst,
  input  logic        s_axis_tvalid,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        lookup_req,
  input  logic        verdict_valid,
  input  logic [3:0]  verdict_flag,
  input  logic        m_axis_tready,
  output logic        m_axis_tvalid,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic [15:0] cnt_fwd,
  output logic [15:0] cnt_drop,
  output logic [15:0] cnt_ovf,
  output logic [15:0] cnt_timeout,
  output logic [1:0]  err_sticky
);
  typedef struct packed { logic last; logic [7:0] keep; logic [63:0] data; } beat_t;
  typedef struct packed { logic hl; logic ovf; } desc_t;
  typedef enum logic [1:0] {IDLE, WAIT, FWD, DISC} state_t;

  localparam int DD = 1 << DATA_AW;
  localparam int QD = 1 << DESC_AW;

  beat_t      dmem [DD];
  desc_t      qmem [QD];
  logic [3:0] vmem [QD];

  logic [DATA_AW:0] wr_ptr, wr_spec, rd_ptr;
  logic [DESC_AW:0] q_wr, q_rd, v_wr, v_rd;
  logic             in_sync, f_hl, f_ovf, err_q, err_v, ld_last;
  logic [15:0]      timer, skip_cnt;
  state_t           state, state_nxt;
  desc_t            cur, head_q;
  beat_t            d_head;
  logic [3:0]       v_head;

  logic d_full, d_empty, q_full, q_empty, v_full, v_empty;
  logic beat_in, beat_wr, ovf_now, hl_now, q_push;
  logic v_pop_skip, v_pop_eg, q_pop, d_pop, ld, out_acc, room;
  logic fwd_inc, drop_inc, to_inc, skip_inc;
  logic unused_flag_bits;

  assign d_full  = (wr_spec[DATA_AW-1:0] == rd_ptr[DATA_AW-1:0]) && (wr_spec[DATA_AW] != rd_ptr[DATA_AW]);
  assign d_empty = (wr_ptr == rd_ptr);
  assign q_full  = (q_wr[DESC_AW-1:0] == q_rd[DESC_AW-1:0]) && (q_wr[DESC_AW] != q_rd[DESC_AW]);
  assign q_empty = (q_wr == q_rd);
  assign v_full  = (v_wr[DESC_AW-1:0] == v_rd[DESC_AW-1:0]) && (v_wr[DESC_AW] != v_rd[DESC_AW]);
  assign v_empty = (v_wr == v_rd);

  assign d_head = dmem[rd_ptr[DATA_AW-1:0]];
  assign head_q = qmem[q_rd[DESC_AW-1:0]];
  assign v_head = vmem[v_rd[DESC_AW-1:0]];
  assign unused_flag_bits = ^{v_head[3], v_head[0]};

  assign beat_in = s_axis_tvalid && in_sync;
  assign ovf_now = f_ovf || d_full;
  assign beat_wr = beat_in && !ovf_now;
  assign hl_now  = f_hl || lookup_req;
  assign q_push  = beat_in && s_axis_tlast && !q_full;

  assign v_pop_skip = (skip_cnt != '0) && !v_empty;
  assign out_acc    = m_axis_tvalid && m_axis_tready;
  assign room       = !m_axis_tvalid || m_axis_tready;
  assign m_axis_tuser = 1'b0;
  assign err_sticky   = {err_q, err_v};

  always_ff @(posedge clk156) begin
    if (beat_wr) dmem[wr_spec[DATA_AW-1:0]] <= '{last: s_axis_tlast, keep: s_axis_tkeep, data: s_axis_tdata};
    if (q_push) qmem[q_wr[DESC_AW-1:0]] <= '{hl: hl_now, ovf: ovf_now};
    if (verdict_valid && !v_full) vmem[v_wr[DESC_AW-1:0]] <= verdict_flag;
  end

  // Ingress: beats land at wr_spec and only become visible when tlast commits wr_ptr.
  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      in_sync <= 1'b0;
      f_hl    <= 1'b0;
      f_ovf   <= 1'b0;
      wr_ptr  <= '0;
      wr_spec <= '0;
      q_wr    <= '0;
      cnt_ovf <= '0;
      err_q   <= 1'b0;
    end else if (s_axis_tvalid && !in_sync) begin
      in_sync <= s_axis_tlast;
    end else if (beat_in) begin
      if (!s_axis_tlast) begin
        f_hl  <= hl_now;
        f_ovf <= ovf_now;
        if (beat_wr) wr_spec <= wr_spec + 1'b1;
      end else begin
        f_hl  <= 1'b0;
        f_ovf <= 1'b0;
        if (q_full || ovf_now) begin
          wr_spec <= wr_ptr;
          cnt_ovf <= cnt_ovf + 16'd1;
          if (q_full) err_q <= 1'b1;
        end else begin
          wr_ptr  <= wr_spec + 1'b1;
          wr_spec <= wr_spec + 1'b1;
        end
        if (q_push) q_wr <= q_wr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      v_wr  <= '0;
      v_rd  <= '0;
      err_v <= 1'b0;
    end else begin
      if (verdict_valid) begin
        if (v_full) err_v <= 1'b1;
        else        v_wr  <= v_wr + 1'b1;
      end
      if (v_pop_skip || v_pop_eg) v_rd <= v_rd + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    q_pop     = 1'b0;
    d_pop     = 1'b0;
    ld        = 1'b0;
    v_pop_eg  = 1'b0;
    fwd_inc   = 1'b0;
    drop_inc  = 1'b0;
    to_inc    = 1'b0;
    skip_inc  = 1'b0;
    case (state)
      IDLE: if (!q_empty) begin
        q_pop = 1'b1;
        if (head_q.hl)        state_nxt = WAIT;
        else if (!head_q.ovf) state_nxt = FWD;
      end
      WAIT: if (skip_cnt == '0 && !v_empty) begin
        v_pop_eg = 1'b1;
        if (cur.ovf) state_nxt = IDLE;
        else if (v_head[2:1] == DROP_STATUS) begin
          state_nxt = DISC;
          drop_inc  = 1'b1;
        end else state_nxt = FWD;
      end else if (timer == 16'(TIMEOUT - 1)) begin
        // fail open; the verdict still owed for this frame is discarded when it arrives
        skip_inc  = 1'b1;
        to_inc    = 1'b1;
        state_nxt = cur.ovf ? IDLE : FWD;
      end
      FWD: begin
        ld    = !ld_last && !d_empty && room;
        d_pop = ld;
        if (out_acc && m_axis_tlast) begin
          fwd_inc   = 1'b1;
          state_nxt = IDLE;
        end
      end
      DISC: if (!d_empty) begin
        d_pop = 1'b1;
        if (d_head.last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      state         <= IDLE;
      cur           <= '0;
      timer         <= '0;
      skip_cnt      <= '0;
      rd_ptr        <= '0;
      q_rd          <= '0;
      ld_last       <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      cnt_fwd       <= '0;
      cnt_drop      <= '0;
      cnt_timeout   <= '0;
    end else begin
      state <= state_nxt;
      if (q_pop) begin
        q_rd    <= q_rd + 1'b1;
        cur     <= head_q;
        timer   <= '0;
        ld_last <= 1'b0;
      end else if (state == WAIT) timer <= timer + 16'd1;
      if (d_pop) rd_ptr <= rd_ptr + 1'b1;
      if (ld) begin
        m_axis_tvalid <= 1'b1;
        {m_axis_tlast, m_axis_tkeep, m_axis_tdata} <= d_head;
        ld_last       <= d_head.last;
      end else if (out_acc) m_axis_tvalid <= 1'b0;
      skip_cnt <= skip_cnt + 16'(skip_inc) - 16'(v_pop_skip);
      if (fwd_inc)  cnt_fwd     <= cnt_fwd + 16'd1;
      if (drop_inc) cnt_drop    <= cnt_drop + 16'd1;
      if (to_inc)   cnt_timeout <= cnt_timeout + 16'd1;
    end
  end
endmodule

// File: tb/tb_eth_filter_gate.sv
// Directed bench for eth_filter_gate: small data FIFO and short timeout so overflow and
// fail-open paths are reachable with short frames.
module tb_eth_filter_gate;
  logic        clk156 = 1'b0;
  logic        eth_rst = 1'b1;
  logic        s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, lookup_req = 1'b0, verdict_valid = 1'b0;
  logic [63:0] s_axis_tdata = '0;
  logic [7:0]  s_axis_tkeep = '0;
  logic [3:0]  verdict_flag = '0;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic [15:0] cnt_fwd, cnt_drop, cnt_ovf, cnt_timeout;
  logic [1:0]  err_sticky;

  always #5 clk156 = ~clk156;

  eth_filter_gate #(.DATA_AW(4), .DESC_AW(4), .TIMEOUT(64), .DROP_STATUS(2'b11)) dut (
    .clk156(clk156), .eth_rst(eth_rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast), .lookup_req(lookup_req),
    .verdict_valid(verdict_valid), .verdict_flag(verdict_flag),
    .m_axis_tready(m_axis_tready), .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .cnt_fwd(cnt_fwd), .cnt_drop(cnt_drop), .cnt_ovf(cnt_ovf), .cnt_timeout(cnt_timeout),
    .err_sticky(err_sticky)
  );

  int          n_cmp = 0, n_bad = 0;
  logic [72:0] got [512];
  int          got_n = 0, tv_cyc = 0, rd_n = 0;
  logic        tog_en = 1'b0;

  // capture accepted output beats
  always @(negedge clk156) begin
    if (m_axis_tvalid) tv_cyc <= tv_cyc + 1;
    if (m_axis_tvalid && m_axis_tready && got_n < 512) begin
      got[got_n] <= {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
      got_n      <= got_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [72:0] obs, input logic [72:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [72:0] beat_of(input logic [7:0] tag, input int i, input int n);
    logic [63:0] d;
    d = {tag, 8'hA5, 16'(i), 32'h1234_0000 + 32'(i * 17)};
    return {(i == n - 1), ((i == n - 1) ? 8'h3F : 8'hFF), d};
  endfunction

  task automatic tick();
    @(posedge clk156);
    #1;
    if (tog_en) m_axis_tready = ~m_axis_tready;
  endtask

  task automatic send(input logic [7:0] tag, input int n, input int lk, input int vb, input logic [3:0] vf);
    for (int i = 0; i < n; i++) begin
      {s_axis_tlast, s_axis_tkeep, s_axis_tdata} = beat_of(tag, i, n);
      s_axis_tvalid = 1'b1;
      lookup_req    = (i == lk);
      verdict_valid = (i == vb);
      verdict_flag  = vf;
      tick();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    lookup_req    = 1'b0;
    verdict_valid = 1'b0;
  endtask

  task automatic verdict(input logic [3:0] vf);
    verdict_valid = 1'b1;
    verdict_flag  = vf;
    tick();
    verdict_valid = 1'b0;
  endtask

  task automatic expect_frame(input string nm, input logic [7:0] tag, input int n);
    int k;
    k = 0;
    while (got_n - rd_n < n && k < 400) begin
      tick();
      k++;
    end
    chk({nm, "_beats"}, 73'(got_n - rd_n), 73'(n));
    for (int i = 0; i < n; i++) begin
      chk({nm, "_beat"}, (rd_n < 512) ? got[rd_n] : 'x, beat_of(tag, i, n));
      rd_n++;
    end
  endtask

  initial begin
    int n, tv0;
    repeat (3) tick();
    eth_rst = 1'b0;
    chk("rst_tvalid", 73'(m_axis_tvalid), 0);
    chk("rst_cnt", {cnt_fwd, cnt_drop, cnt_ovf, cnt_timeout, err_sticky}, 0);
    chk("rst_tuser", 73'(m_axis_tuser), 0);

    // first tlast after reset only establishes frame sync
    send(8'h00, 1, -1, -1, 4'h0);
    repeat (10) tick();
    chk("sync_ignored", 73'(got_n), 0);

    // T1 pass-through
    send(8'hA1, 8, -1, -1, 4'h0);
    expect_frame("t1", 8'hA1, 8);
    tick();
    chk("t1_fwd", 73'(cnt_fwd), 1);
    chk("t1_tuser", 73'(m_axis_tuser), 0);
    chk("t1_idle", 73'(m_axis_tvalid), 0);

    // T2 late drop verdict
    tv0 = tv_cyc;
    send(8'hB2, 12, 10, -1, 4'h0);
    repeat (30) tick();
    verdict(4'b0111);
    repeat (20) tick();
    chk("t2_drop", 73'(cnt_drop), 1);
    chk("t2_no_tvalid", 73'(tv_cyc - tv0), 0);
    chk("t2_fifo_empty", 73'(dut.rd_ptr == dut.wr_ptr), 1);
    chk("t2_cnts", {cnt_fwd, cnt_timeout, cnt_ovf}, {16'd1, 16'd0, 16'd0});

    // T3 early pass verdict, tready toggling
    tog_en = 1'b1;
    send(8'hC3, 6, 0, 2, 4'b0011);
    n = 0;
    while (!m_axis_tvalid && n < 10) begin
      tick();
      n++;
    end
    chk("t3_latency", 73'(n >= 1 && n <= 3), 1);
    expect_frame("t3", 8'hC3, 6);
    tog_en = 1'b0;
    m_axis_tready = 1'b1;
    tick();
    chk("t3_fwd", 73'(cnt_fwd), 2);

    // T4 timeout on A, late A verdict skipped, B verdict applied
    send(8'hD4, 4, 1, -1, 4'h0);
    send(8'hE5, 4, 3, -1, 4'h0);
    repeat (50) tick();
    chk("t4_hold", 73'(got_n - rd_n), 0);
    expect_frame("t4a", 8'hD4, 4);
    chk("t4_timeout", 73'(cnt_timeout), 1);
    verdict(4'b0111);
    verdict(4'b0011);
    expect_frame("t4b", 8'hE5, 4);
    tick();
    chk("t4_cnts", {cnt_fwd, cnt_drop, cnt_timeout}, {16'd4, 16'd1, 16'd1});

    // T5 data FIFO overflow; ovf frame still consumes its verdict
    send(8'hF6, 20, 0, -1, 4'h0);
    send(8'h17, 8, -1, -1, 4'h0);
    verdict(4'b0011);
    expect_frame("t5", 8'h17, 8);
    chk("t5_ovf", 73'(cnt_ovf), 1);
    send(8'h28, 4, 1, -1, 4'h0);
    repeat (3) tick();
    verdict(4'b0111);
    repeat (15) tick();
    chk("t5_drop", 73'(cnt_drop), 2);
    chk("t5_no_out", 73'(got_n - rd_n), 0);
    chk("t5_fwd", 73'(cnt_fwd), 5);

    // verdict FIFO overflow sets its sticky bit
    for (int i = 0; i < 17; i++) begin
      verdict_valid = 1'b1;
      verdict_flag  = 4'b0011;
      tick();
    end
    verdict_valid = 1'b0;
    tick();
    chk("vovf_err", 73'(err_sticky), 2'b01);

    // T6 reset mid-frame with a stalled output beat pending
    m_axis_tready = 1'b0;
    send(8'h39, 4, -1, -1, 4'h0);
    repeat (4) tick();
    chk("t6_pending", 73'(m_axis_tvalid), 1);
    for (int i = 0; i < 6; i++) begin
      {s_axis_tlast, s_axis_tkeep, s_axis_tdata} = beat_of(8'h4A, i, 6);
      s_axis_tvalid = 1'b1;
      eth_rst = (i == 2);
      tick();
      if (i == 2) begin
        chk("t6_rst_tvalid", 73'(m_axis_tvalid), 0);
        chk("t6_rst_data", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, 0);
        chk("t6_rst_cnt", {cnt_fwd, cnt_drop, cnt_ovf, cnt_timeout, err_sticky}, 0);
      end
    end
    eth_rst = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    repeat (8) tick();
    chk("t6_tail_ignored", 73'(got_n - rd_n), 0);
    send(8'h5B, 5, -1, -1, 4'h0);
    expect_frame("t6", 8'h5B, 5);
    tick();
    chk("t6_cnts", {cnt_fwd, cnt_ovf, cnt_drop}, {16'd1, 16'd0, 16'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1);
  end
endmodule
